// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - two-requester (fetch/data) arbiter for one shared memory port
//
// Purpose: shares a single request/acknowledge memory port between an
// instruction-fetch requester (IF) and a data-memory requester (DM). Data wins
// in IDLE; when both keep requesting, ownership alternates on every ack.
// Optional compile macro: MIPS_ARB_TIMEOUT_EN adds an ack-wait watchdog that
// ends a SERVE state with err=1 after TIMEOUT cycles without mem_ack.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   if_req, if_addr             fetch request and address
//   if_gnt, if_done, if_rdata   fetch grant pulse, completion, read data
//   dm_req, dm_we, dm_addr,
//   dm_wdata                    data request, write enable, address, write data
//   dm_gnt, dm_done, dm_rdata   data grant pulse, completion, read data
//   mem_req, mem_we, mem_addr,
//   mem_wdata                   shared memory request side
//   mem_ack, mem_rdata          single-cycle acknowledge, read data valid with it
//   err                         timeout pulse (constant 0 without the macro)

module mips_mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_done,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 dm_req,
  input  logic                 dm_we,
  input  logic [WORD_SIZE-1:0] dm_addr,
  input  logic [WORD_SIZE-1:0] dm_wdata,
  output logic                 dm_gnt,
  output logic                 dm_done,
  output logic [WORD_SIZE-1:0] dm_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 err
);

  // Reject an out-of-range watchdog limit at elaboration time.
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mips_mem_arbiter: TIMEOUT must be within 2..255");
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_DM = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 if_gnt_q, if_gnt_d;
  logic                 dm_gnt_q, dm_gnt_d;

  logic serving;   // any SERVE state
  logic tmo;       // watchdog expiry this cycle
  logic finish;    // current transaction ends this cycle (ack or timeout)
  logic grant_if;  // enter SERVE_IF on the next edge
  logic grant_dm;  // enter SERVE_DM on the next edge

  assign serving = (state_q != IDLE);

`ifdef MIPS_ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // The counter holds the number of ack-less cycles already spent in this
  // SERVE state, so it reads TIMEOUT-1 in the TIMEOUT-th cycle.
  assign tmo = serving && !mem_ack && (cnt_q == TMO_LAST);
`else
  assign tmo = 1'b0;
`endif

  assign finish = serving && (mem_ack || tmo);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    if_gnt_d = 1'b0;
    dm_gnt_d = 1'b0;
    grant_if = 1'b0;
    grant_dm = 1'b0;
`ifdef MIPS_ARB_TIMEOUT_EN
    cnt_d    = (serving && !mem_ack) ? cnt_q + 8'd1 : cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (dm_req) begin
          grant_dm = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end
      end
      // On completion only the other requester is looked at, which gives
      // strict alternation when both keep their requests raised.
      SERVE_IF: begin
        if (finish) begin
          if (dm_req) grant_dm = 1'b1;
          else        state_d  = IDLE;
        end
      end
      SERVE_DM: begin
        if (finish) begin
          if (if_req) grant_if = 1'b1;
          else        state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant_dm) begin
      state_d  = SERVE_DM;
      addr_d   = dm_addr;
      we_d     = dm_we;
      wdata_d  = dm_wdata;
      dm_gnt_d = 1'b1;
`ifdef MIPS_ARB_TIMEOUT_EN
      cnt_d    = 8'd0;
`endif
    end else if (grant_if) begin
      state_d  = SERVE_IF;
      addr_d   = if_addr;
      we_d     = 1'b0;
      wdata_d  = '0;
      if_gnt_d = 1'b1;
`ifdef MIPS_ARB_TIMEOUT_EN
      cnt_d    = 8'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      if_gnt_q <= 1'b0;
      dm_gnt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      if_gnt_q <= if_gnt_d;
      dm_gnt_q <= dm_gnt_d;
    end
  end

`ifdef MIPS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign mem_req   = serving;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_gnt  = if_gnt_q;
  assign dm_gnt  = dm_gnt_q;
  assign if_done = (state_q == SERVE_IF) && finish;
  assign dm_done = (state_q == SERVE_DM) && finish;

  // Read data is only forwarded with a real ack; a timeout completes with 0.
  assign if_rdata = ((state_q == SERVE_IF) && mem_ack) ? mem_rdata : '0;
  assign dm_rdata = ((state_q == SERVE_DM) && mem_ack) ? mem_rdata : '0;

  assign err = tmo;

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32: data and address width.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum ack-wait cycles, legal range 2..255; used only with MIPS_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports if_req  input  1, if_addr  input  WORD_SIZE: instruction-fetch request and address.
REQ-006 SHALL have ports if_gnt  output  1, if_done  output  1, if_rdata  output  WORD_SIZE: fetch grant, completion, read data.
REQ-007 SHALL have ports dm_req  input  1, dm_we  input  1, dm_addr  input  WORD_SIZE, dm_wdata  input  WORD_SIZE: data-memory request.
REQ-008 SHALL have ports dm_gnt  output  1, dm_done  output  1, dm_rdata  output  WORD_SIZE: data grant, completion, read data.
REQ-009 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  WORD_SIZE, mem_wdata  output  WORD_SIZE: shared memory port.
REQ-010 SHALL have ports mem_ack  input  1, mem_rdata  input  WORD_SIZE: single-cycle memory acknowledge and read data valid with it.
REQ-011 SHALL have port err  output  1: timeout pulse; tied 0 without MIPS_ARB_TIMEOUT_EN.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE_IF, SERVE_DM.
REQ-013 IDLE: dm_req=1 -> SERVE_DM; else if_req=1 -> SERVE_IF; else stay (data has priority).
REQ-014 On each entry to a SERVE state, SHALL latch owner's addr, we (0 for fetch), wdata into registers driving mem_addr/mem_we/mem_wdata.
REQ-015 xx_gnt SHALL be a registered one-cycle pulse in the first cycle of the owner's SERVE state.
REQ-016 mem_req SHALL be 1 in every SERVE cycle and 0 in IDLE.
REQ-017 xx_done SHALL be combinational: mem_ack AND owner's SERVE state; xx_rdata SHALL equal mem_rdata while xx_done=1, else 0.
REQ-018 On mem_ack in SERVE_X: next state SHALL be SERVE of the other requester if its req=1, else IDLE; current owner's req SHALL NOT be considered that cycle (alternation when both are busy).
REQ-019 Latency: request seen in IDLE at edge N -> mem_req=1 from cycle N+1; earliest done in cycle N+1.
REQ-020 mem_ack in IDLE SHALL be ignored; requests SHALL NOT be dropped before done (requester obligation, not checked).
REQ-021 Requester SHALL deassert req on the edge where its done=1; arbiter SHALL tolerate req held high (new transaction).

Reset
REQ-022 rst=0 SHALL asynchronously force IDLE; mem_req, mem_we, gnt, err 0; mem_addr, mem_wdata 0; wait counter 0.
REQ-023 Reset mid-transaction SHALL abort it without done; first grant no earlier than the first edge after rst=1.

Configuration
REQ-024 Macro MIPS_ARB_TIMEOUT_EN SHALL compile in an 8-bit wait counter, cleared on SERVE entry, incremented each SERVE cycle with mem_ack=0.
REQ-025 With macro: counter==TIMEOUT-1 and mem_ack=0 SHALL assert err and owner's done combinationally that cycle, rdata 0, then transition as in REQ-018.
REQ-026 Without macro: no counter; SERVE waits for mem_ack indefinitely; err constant 0.

Verification
REQ-027 Reset: rst=0 mid-SERVE_DM -> mem_req=0 immediately, no dm_done; after rst=1, grants resume.
REQ-028 Single fetch: if_req=1, if_addr=0x00400000, mem_ack after 3 cycles with mem_rdata=0x8C080004 -> if_gnt pulse, mem_addr=0x00400000, mem_we=0, if_done 1 cycle, if_rdata=0x8C080004.
REQ-029 Priority: if_req and dm_req rise same cycle, dm_we=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF -> dm granted first with mem_we=1, fetch served immediately after dm ack.
REQ-030 Alternation: both held high for 6 acks (ack every cycle) -> owners DM,IF,DM,IF,DM,IF, no IDLE cycle.
REQ-031 Timeout (macro on, TIMEOUT=16): fetch, no mem_ack -> err and if_done in 16th SERVE cycle, if_rdata=0, IDLE next.
REQ-032 Stray mem_ack=1 in IDLE -> no done, no state change.
